// File: rtl/rapid_pkg.sv
// rapid_pkg: shared width, default reset PC and fetch buffer entry type
// No ports; imported by the fetch unit, its interface and the testbench.
package rapid_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fetch_entry_s;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decoder handshake signals
// Modports: master = fetch unit side (drives o_*), slave = memory/decoder/branch side (drives i_*).
interface fetch_unit_if;
  import rapid_pkg::*;
  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_gnt;
  logic            i_imem_rvalid;
  logic [XLEN-1:0] i_imem_rdata;
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_valid;
  logic [XLEN-1:0] o_instruction;
  logic [XLEN-1:0] o_pc;
  logic            i_ready;
  modport master (
    output o_imem_req, o_imem_addr, o_valid, o_instruction, o_pc,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_redirect, i_redirect_pc, i_ready
  );
  modport slave (
    input  o_imem_req, o_imem_addr, o_valid, o_instruction, o_pc,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count, no read bypass
// Ports: clk, rst, flush, push/push_data, pop, head (oldest entry), count (occupancy).
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T = logic [31:0],
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);
  T mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with in-order buffer and redirect flush
// Ports: i_clk, i_rst (sync, active-high), bus (fetch_unit_if.master: imem req/gnt/rvalid, redirect, decoder valid/ready).
module fetch_unit
  import rapid_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 4
) (
  input logic          i_clk,
  input logic          i_rst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = FIFO_DEPTH;
  logic [XLEN-1:0] fetch_pc, tag_pc;
  logic [CW-1:0] in_flight, drop_count, buf_count, tag_count;
  fetch_entry_s head;
  logic grant, keep, pop;
  // Outstanding requests (even doomed ones) reserve buffer slots, so a kept response always fits.
  assign bus.o_imem_req  = !i_rst && !bus.i_redirect && ({1'b0, in_flight} + {1'b0, buf_count} < CREDITS);
  assign bus.o_imem_addr = i_rst ? RESET_PC : fetch_pc;
  assign grant = bus.o_imem_req && bus.i_imem_gnt;
  assign keep  = bus.i_imem_rvalid && drop_count == '0 && !bus.i_redirect && tag_count != '0;
  assign bus.o_valid       = !i_rst && !bus.i_redirect && buf_count != '0;
  assign bus.o_pc          = bus.o_valid ? head.pc : '0;
  assign bus.o_instruction = bus.o_valid ? head.instruction : '0;
  assign pop = bus.o_valid && bus.i_ready;
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [XLEN-1:0])) tag_q (
    .clk(i_clk), .rst(i_rst), .flush(bus.i_redirect),
    .push(grant), .push_data(fetch_pc), .pop(keep),
    .head(tag_pc), .count(tag_count)
  );
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_s)) buf_q (
    .clk(i_clk), .rst(i_rst), .flush(bus.i_redirect),
    .push(keep), .push_data(fetch_entry_s'{tag_pc, bus.i_imem_rdata}), .pop(pop),
    .head(head), .count(buf_count)
  );
  // A response landing in the redirect cycle is itself discarded, so only the rest remain to drop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc   <= RESET_PC;
      in_flight  <= '0;
      drop_count <= '0;
    end else begin
      in_flight  <= in_flight + CW'(grant) - CW'(bus.i_imem_rvalid);
      drop_count <= bus.i_redirect ? in_flight - CW'(bus.i_imem_rvalid)
                                   : drop_count - CW'(bus.i_imem_rvalid && drop_count != '0);
      fetch_pc   <= bus.i_redirect ? (bus.i_redirect_pc & ~XLEN'(3))
                  : grant          ? fetch_pc + XLEN'(4) : fetch_pc;
    end
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), the instruction buffer entries.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port o_imem_req  output  1  fetch request valid.
REQ-006 SHALL have port o_imem_addr  output  XLEN  fetch byte address, word aligned.
REQ-007 SHALL have port i_imem_gnt  input  1  request accepted when o_imem_req & i_imem_gnt.
REQ-008 SHALL have port i_imem_rvalid  input  1  response valid; one per accepted request, in order, >=1 cycle after grant.
REQ-009 SHALL have port i_imem_rdata  input  XLEN  instruction word for the oldest outstanding request.
REQ-010 SHALL have port i_redirect  input  1  branch/jump redirect, single-cycle pulse.
REQ-011 SHALL have port i_redirect_pc  input  XLEN  new fetch target; bits [1:0] ignored, treated as 0.
REQ-012 SHALL have port o_valid  output  1  instruction available to decoder.
REQ-013 SHALL have port o_instruction  output  XLEN  instruction word, feeds decoder i_instruction.
REQ-014 SHALL have port o_pc  output  XLEN  address of o_instruction.
REQ-015 SHALL have port i_ready  input  1  decoder accepts; transfer on o_valid & i_ready.

Function
REQ-016 SHALL hold fetch_pc; o_imem_addr = fetch_pc; on accepted request fetch_pc += 4 (mod 2^XLEN, wrap at 32'hFFFF_FFFC -> 0).
REQ-017 SHALL assert o_imem_req only when i_redirect = 0 and (in_flight + fifo_count) < FIFO_DEPTH; in_flight counts all accepted, unreturned requests, including ones marked for drop.
REQ-018 SHALL record the request PC at grant in a tag queue of depth FIFO_DEPTH; on a kept response, write {tag PC, i_imem_rdata} into the buffer.
REQ-019 SHALL present buffer head on o_valid/o_pc/o_instruction; written entry visible the cycle after i_imem_rvalid (registered, no bypass).
REQ-020 SHALL hold o_pc/o_instruction stable while o_valid & !i_ready.
REQ-021 SHALL permit push and pop in the same cycle, including when full or holding one entry.
REQ-022 SHALL sustain one instruction per cycle with 1-cycle memory latency, i_imem_gnt = 1, i_ready = 1.
REQ-023 On i_redirect: flush buffer and tag queue; set fetch_pc = {i_redirect_pc[XLEN-1:2], 2'b00}; set drop_count = in_flight (including a response arriving that same cycle, which is discarded); force o_valid = 0 that cycle.
REQ-024 SHALL discard responses while drop_count > 0, decrementing per response; first kept response is the first post-redirect request.
REQ-025 Back-to-back redirects: latest wins; drop_count recomputed from in_flight each time.
REQ-026 SHALL not overflow buffer: credit rule of REQ-017 guarantees space for every kept response.

Reset
REQ-027 While i_rst = 1: o_imem_req = 0, o_valid = 0, o_imem_addr = RESET_PC, o_pc = 0, o_instruction = 0; fetch_pc = RESET_PC; counters, buffer, tag queue cleared.
REQ-028 First request SHALL issue the first cycle i_rst = 0, address RESET_PC.
REQ-029 Reset mid-operation SHALL abandon outstanding requests; the memory side is reset together, so no responses are dropped post-reset.

Structure
REQ-030 rapid_pkg SHALL hold XLEN, the default RESET_PC constant, and typedef fetch_entry_s {pc, instruction}.
REQ-031 Buffer SHALL be a sub-module fetch_fifo (synchronous, parameterised depth/type, count output); tag queue reuses it.

Verification
REQ-032 Reset, 1-cycle memory, i_ready = 1, RESET_PC = 0 -> o_valid from cycle 3 after reset release, o_pc 0,4,8,... every cycle, no gaps.
REQ-033 i_ready = 0 for 10 cycles -> exactly 4 instructions buffered, o_imem_req low, o_pc held at 0; release -> 0,4,8,12,16 in order, none lost or duplicated.
REQ-034 Memory latency 3, i_redirect to 32'h0000_0103 with 2 in flight -> both stale responses dropped; next o_pc = 32'h0000_0100.
REQ-035 i_redirect in the same cycle as i_imem_rvalid and a full buffer -> that response discarded, o_valid = 0 that cycle, next o_pc = redirect target.
REQ-036 Redirect to 32'hFFFF_FFF8, free-running -> o_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Random gnt/rvalid/ready/redirect with scoreboard -> every o_pc/o_instruction pair matches memory model and program order; i_rst mid-stream returns to REQ-027 values next cycle.
